zombie_spawner: RTL and testbench
=================================

ZOMBIE_SPAWNER -- requirements
Module: zombie_spawner

Interface
REQ-001 SHALL have parameter GAP_CYC, default 50_000_000, cycles between a hit/miss and the next zombie.
REQ-002 SHALL have parameter TIMEOUT, default 100_000_000, cycles a zombie stays lit awaiting a punch.
REQ-003 SHALL have parameter LIVES, default 3, range 1..3, lives at game start.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-low (rst==0 at posedge clk resets the block).
REQ-006 start  input  1  level, sampled each cycle; begins a game from IDLE or OVER.
REQ-007 btn1, btn2, btn3  input  1 each  player punch buttons, pre-synchronised, active-high.
REQ-008 led  output  [3:1]  zombie lane indicator, one-hot while a zombie is shown.
REQ-009 score  output  [7:0]  hit count, saturating.
REQ-010 lives  output  [1:0]  remaining lives.
REQ-011 hit  output  1  one-cycle pulse per scored hit.
REQ-012 miss  output  1  one-cycle pulse per wrong press or timeout.
REQ-013 game_over  output  1  high while in OVER.

Function
REQ-014 SHALL register buttons into btn_q[3:1] every cycle; press edge[i] = btn[i] & ~btn_q[i]; held buttons SHALL NOT generate further edges.
REQ-015 SHALL run an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, advancing every cycle in all states.
REQ-016 Lane choice at GAP->SHOW transition from lfsr[1:0]: 00->1, 01->2, 10->3, 11->2.
REQ-017 States: IDLE, GAP, SHOW, OVER; all outputs registered.
REQ-018 IDLE: led=000; start==1 -> GAP, gap counter loaded GAP_CYC-1.
REQ-019 GAP: led=000; counter decrements each cycle; at counter==0 -> SHOW, led=one-hot chosen lane, timer loaded TIMEOUT-1; buttons ignored.
REQ-020 SHOW: exactly one edge, on lit lane -> next cycle hit=1, score+1 (hold at 255), led=000, -> GAP with gap reload.
REQ-021 SHOW: edge on an unlit lane, or two or more simultaneous edges -> miss=1, lives-1, led=000.
REQ-022 SHOW: timer==0 with no edge -> miss=1, lives-1, led=000; led therefore lit exactly TIMEOUT cycles.
REQ-023 Press on the timer==0 cycle SHALL be judged as a press (hit or wrong), not timeout.
REQ-024 After a miss: lives reaching 0 -> OVER, else -> GAP with gap reload.
REQ-025 OVER: led=111, game_over=1, score and lives frozen; start==1 -> score=0, lives=LIVES, game_over=0, -> GAP.
REQ-026 hit and miss SHALL never be high in the same cycle; each is high at most one cycle per zombie.
REQ-027 start SHALL be ignored in GAP and SHOW.

Reset
REQ-028 On rst==0: state IDLE, led=000, score=0, lives=LIVES, hit=0, miss=0, game_over=0, btn_q=000, lfsr=8'hA5, counters 0.
REQ-029 Reset SHALL take priority over all events, including mid-SHOW and in OVER; no hit/miss pulse emitted for an aborted zombie.

Verification (GAP_CYC=4, TIMEOUT=8, LIVES=3)
REQ-030 Reset, start 1 cycle -> led=000 for 4 cycles of GAP, then led one-hot per REQ-016 mapping of lfsr at that cycle.
REQ-031 In SHOW, pulse matching button on 3rd lit cycle -> hit=1 one cycle, score=1, led=000, lives=3, new zombie 4 cycles later.
REQ-032 In SHOW, no press -> led lit exactly 8 cycles, then miss=1, lives=2; press on 8th lit cycle instead -> hit, score increments.
REQ-033 In SHOW, press btn1+btn3 same cycle with lane 1 lit -> miss, lives-1; button held high from GAP into SHOW -> no hit, timeout miss.
REQ-034 Three misses -> game_over=1, led=111, lives=0; start -> score=0, lives=3, game_over=0, GAP entered; score held at 255 after 256+ hits.
REQ-035 rst low mid-SHOW -> next cycle all outputs at REQ-028 values, no hit/miss pulse.

Source files
------------

// File: rtl/zombie_spawner.sv
// rtl/zombie_spawner.sv - whack-a-zombie game controller: LFSR lane pick, punch judging, score/lives
module zombie_spawner #(
    parameter int GAP_CYC = 50_000_000,
    parameter int TIMEOUT = 100_000_000,
    parameter int LIVES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       btn1,
    input  logic       btn2,
    input  logic       btn3,
    output logic [3:1] led,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       hit,
    output logic       miss,
    output logic       game_over
);

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_SHOW, S_OVER} state_t;

    localparam logic [31:0] GAP_LOAD   = 32'(GAP_CYC - 1);
    localparam logic [31:0] TO_LOAD    = 32'(TIMEOUT - 1);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [2:0]  btn_q, btn_d;
    logic [2:0]  led_q, led_d;
    logic [7:0]  score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;
    logic        go_q, go_d;

    logic [2:0]  press_w;
    logic [2:0]  lane_w;
    logic        miss_ev;

    always_comb begin
        btn_d   = {btn3, btn2, btn1};
        press_w = btn_d & ~btn_q;
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        case (lfsr_q[1:0])
            2'b00:   lane_w = 3'b001;
            2'b01:   lane_w = 3'b010;
            2'b10:   lane_w = 3'b100;
            default: lane_w = 3'b010;
        endcase

        state_d = state_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        score_d = score_q;
        lives_d = lives_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        go_d    = go_q;
        miss_ev = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (cnt_q == 32'd0) begin
                    state_d = S_SHOW;
                    cnt_d   = TO_LOAD;
                    led_d   = lane_w;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_SHOW: begin
                // A press on the final timer cycle is still judged as a press.
                if (press_w != 3'b000) begin
                    if (press_w == led_q) begin
                        hit_d   = 1'b1;
                        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        led_d   = 3'b000;
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        miss_ev = 1'b1;
                    end
                end else if (cnt_q == 32'd0) begin
                    miss_ev = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
                if (miss_ev) begin
                    miss_d  = 1'b1;
                    lives_d = lives_q - 2'd1;
                    if (lives_q <= 2'd1) begin
                        state_d = S_OVER;
                        led_d   = 3'b111;
                        go_d    = 1'b1;
                        cnt_d   = 32'd0;
                    end else begin
                        state_d = S_GAP;
                        led_d   = 3'b000;
                        cnt_d   = GAP_LOAD;
                    end
                end
            end
            default: begin
                if (start) begin
                    score_d = 8'd0;
                    lives_d = LIVES_INIT;
                    go_d    = 1'b0;
                    led_d   = 3'b000;
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 32'd0;
            lfsr_q  <= 8'hA5;
            btn_q   <= 3'b000;
            led_q   <= 3'b000;
            score_q <= 8'd0;
            lives_q <= LIVES_INIT;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            btn_q   <= btn_d;
            led_q   <= led_d;
            score_q <= score_d;
            lives_q <= lives_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            go_q    <= go_d;
        end
    end

    assign led       = led_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign game_over = go_q;

endmodule

// File: tb/tb_zombie_spawner.sv
// tb/tb_zombie_spawner.sv - scoreboard bench for zombie_spawner (GAP_CYC=4, TIMEOUT=8, LIVES=3)
module tb_zombie_spawner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       btn1 = 1'b0, btn2 = 1'b0, btn3 = 1'b0;
    logic [3:1] led;
    logic [7:0] score;
    logic [1:0] lives;
    logic       hit, miss, game_over;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       is_hit;
        logic [7:0] score;
        logic [1:0] lives;
    } ev_t;

    ev_t sb_q[$];
    ev_t mon_e;

    logic [7:0] m_lfsr, m_lfsr_prev;
    int exp_score;
    int exp_lives;

    zombie_spawner #(.GAP_CYC(4), .TIMEOUT(8), .LIVES(3)) dut (
        .clk(clk), .rst(rst), .start(start),
        .btn1(btn1), .btn2(btn2), .btn3(btn3),
        .led(led), .score(score), .lives(lives),
        .hit(hit), .miss(miss), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Reference LFSR; m_lfsr_prev is the value the DUT saw on the edge just taken.
    always @(posedge clk) begin
        m_lfsr_prev <= m_lfsr;
        if (!rst) m_lfsr <= 8'hA5;
        else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    always @(posedge clk) begin
        #1;
        if (hit || miss) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: hit=%0b miss=%0b, required no pulse", hit, miss);
            end else begin
                mon_e = sb_q.pop_front();
                if ({hit, miss, score, lives} !== {mon_e.is_hit, ~mon_e.is_hit, mon_e.score, mon_e.lives}) begin
                    errors++;
                    $display("FAIL pulse_result: hit=%0b miss=%0b score=%0d lives=%0d, required hit=%0b miss=%0b score=%0d lives=%0d",
                             hit, miss, score, lives, mon_e.is_hit, ~mon_e.is_hit, mon_e.score, mon_e.lives);
                end
            end
        end
    end

    function automatic logic [2:0] lane_of(input logic [7:0] l);
        case (l[1:0])
            2'b00:   return 3'b001;
            2'b01:   return 3'b010;
            2'b10:   return 3'b100;
            default: return 3'b010;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input logic [2:0] b);
        {btn3, btn2, btn1} = b;
    endtask

    task automatic press(input logic [2:0] b, input logic exp_hit);
        if (exp_hit) begin
            if (exp_score < 255) exp_score++;
        end else begin
            exp_lives--;
        end
        sb_q.push_back('{exp_hit, 8'(exp_score), 2'(exp_lives)});
        set_btn(b);
        step(1);
        set_btn(3'b000);
    endtask

    // Expects 4 dark GAP samples, then returns on the first lit sample.
    task automatic wait_zombie(output logic [2:0] lane);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (led !== 3'b000) begin
                errors++;
                $display("FAIL gap_led[%0d]: led=%b, required 000", i, led);
            end
            step(1);
        end
        lane = lane_of(m_lfsr_prev);
        checks++;
        if (led !== lane) begin
            errors++;
            $display("FAIL show_lane: led=%b, required %b", led, lane);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_btn(3'b000);
        step(1);
        exp_score = 0;
        exp_lives = 3;
        checks++;
        if ({led, score, lives, hit, miss, game_over} !== {3'b000, 8'd0, 2'd3, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: led=%b score=%0d lives=%0d hit=%0b miss=%0b go=%0b, required 000/0/3/0/0/0",
                     led, score, lives, hit, miss, game_over);
        end
        rst = 1'b1;
    endtask

    task automatic start_game();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_first_hit();
        logic [2:0] l;
        start_game();
        wait_zombie(l);
        step(2);
        press(l, 1'b1);
        checks++;
        if ({led, score, lives} !== {3'b000, 8'd1, 2'd3}) begin
            errors++;
            $display("FAIL hit_state: led=%b score=%0d lives=%0d, required 000/1/3", led, score, lives);
        end
    endtask

    task automatic test_timeout();
        logic [2:0] l;
        wait_zombie(l);
        for (int i = 2; i <= 8; i++) begin
            step(1);
            checks++;
            if (led !== l) begin
                errors++;
                $display("FAIL timeout_lit[%0d]: led=%b, required %b", i, led, l);
            end
        end
        exp_lives--;
        sb_q.push_back('{1'b0, 8'(exp_score), 2'(exp_lives)});
        step(1);
        checks++;
        if (led !== 3'b000) begin
            errors++;
            $display("FAIL timeout_dark: led=%b, required 000", led);
        end
    endtask

    task automatic test_late_hit();
        logic [2:0] l;
        wait_zombie(l);
        step(7);
        press(l, 1'b1);
    endtask

    task automatic test_multi_press();
        logic [2:0] l;
        wait_zombie(l);
        press(l | ((l == 3'b001) ? 3'b100 : 3'b001), 1'b0);
    endtask

    task automatic test_held_to_over();
        logic [2:0] l;
        set_btn(3'b111);
        wait_zombie(l);
        step(7);
        exp_lives--;
        sb_q.push_back('{1'b0, 8'(exp_score), 2'(exp_lives)});
        step(1);
        set_btn(3'b000);
        checks++;
        if ({game_over, led, lives} !== {1'b1, 3'b111, 2'd0}) begin
            errors++;
            $display("FAIL over_state: go=%0b led=%b lives=%0d, required 1/111/0", game_over, led, lives);
        end
        set_btn(3'b010);
        step(3);
        set_btn(3'b000);
        checks++;
        if ({game_over, led, lives, score} !== {1'b1, 3'b111, 2'd0, 8'(exp_score)}) begin
            errors++;
            $display("FAIL over_frozen: go=%0b led=%b lives=%0d score=%0d, required 1/111/0/%0d",
                     game_over, led, lives, score, exp_score);
        end
    endtask

    task automatic test_restart_wrong_lane();
        logic [2:0] l;
        start_game();
        exp_score = 0;
        exp_lives = 3;
        checks++;
        if ({game_over, score, lives, led} !== {1'b0, 8'd0, 2'd3, 3'b000}) begin
            errors++;
            $display("FAIL restart_state: go=%0b score=%0d lives=%0d led=%b, required 0/0/3/000",
                     game_over, score, lives, led);
        end
        wait_zombie(l);
        press((l == 3'b100) ? 3'b001 : 3'b100, 1'b0);
    endtask

    task automatic test_reset_mid_show();
        logic [2:0] l;
        wait_zombie(l);
        step(2);
        set_btn(l);
        do_reset();
        set_btn(3'b000);
        step(2);
        checks++;
        if ({led, hit, miss} !== 5'b0) begin
            errors++;
            $display("FAIL reset_quiet: led=%b hit=%0b miss=%0b, required 000/0/0", led, hit, miss);
        end
    endtask

    task automatic test_saturation();
        logic [2:0] l;
        start = 1'b1;
        step(1);
        for (int n = 0; n < 260; n++) begin
            wait_zombie(l);
            press(l, 1'b1);
        end
        start = 1'b0;
        checks++;
        if ({score, lives} !== {8'd255, 2'd3}) begin
            errors++;
            $display("FAIL score_saturate: score=%0d lives=%0d, required 255/3", score, lives);
        end
    endtask

    initial begin
        exp_score = 0;
        exp_lives = 3;
        test_reset();
        test_first_hit();
        test_timeout();
        test_late_hit();
        test_multi_press();
        test_held_to_over();
        test_restart_wrong_lane();
        test_reset_mid_show();
        test_saturation();
        step(2);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pulses outstanding, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
